// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main control FSM (fetch/decode/mem/exec/branch).
// Define MULTICYCLE_JUMP_EN to add the J-type JUMP state.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
`ifdef MULTICYCLE_JUMP_EN
    BRANCH = 4'd8,
    JUMP   = 4'd9
`else
    BRANCH = 4'd8
`endif
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef MULTICYCLE_JUMP_EN
  localparam logic [5:0] OP_J   = 6'b000010;
`endif

  state_t state_q;
  logic   is_mem;
  logic   is_r;
  logic   is_beq;
  logic   is_j;

  assign is_mem = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_r   = (opcode == OP_R);
  assign is_beq = (opcode == OP_BEQ);
`ifdef MULTICYCLE_JUMP_EN
  assign is_j   = (opcode == OP_J);
`else
  assign is_j   = 1'b0;
`endif

  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:  if (mem_ready) state_q <= DECODE;
        DECODE: begin
          unique case (1'b1)
            is_mem:  state_q <= MEMADR;
            is_r:    state_q <= EXEC;
            is_beq:  state_q <= BRANCH;
`ifdef MULTICYCLE_JUMP_EN
            is_j:    state_q <= JUMP;
`endif
            default: state_q <= FETCH;
          endcase
        end
        MEMADR: state_q <= (opcode == OP_SW) ? MEMWR : MEMRD;
        MEMRD:  if (mem_ready) state_q <= MEMWB;
        MEMWR:  if (mem_ready) state_q <= FETCH;
        EXEC:   state_q <= ALUWB;
        default: state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !(is_mem || is_r || is_beq || is_j);
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
`ifdef MULTICYCLE_JUMP_EN
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`endif
      default: ;
    endcase
    // Strobes are forced low asynchronously so a reset aborts any write.
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule
